// File: rtl/disp_pkg.sv
// Shared types and segment constants for the seven-segment scan driver.
// Segment encoding is active-high, bit0=a ... bit6=g.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ON   = 2'd2,
      DEAD = 2'd3
   } state_e;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
   import disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_bcd)
         4'd0: o_seg = SEG_0;
         4'd1: o_seg = SEG_1;
         4'd2: o_seg = SEG_2;
         4'd3: o_seg = SEG_3;
         4'd4: o_seg = SEG_4;
         4'd5: o_seg = SEG_5;
         4'd6: o_seg = SEG_6;
         4'd7: o_seg = SEG_7;
         4'd8: o_seg = SEG_8;
         4'd9: o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_disp_scan.sv
// Six-digit multiplexed seven-segment scanner with per-frame digit snapshot and dead time.
// Optional macro DISP_LZB_EN blanks a leading zero in the hour tens digit.
module seg_disp_scan
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 3,
   parameter int DEAD_CYC = 1
) (
   input  logic       i_clk_disp,
   input  logic       i_rst_n,
   input  logic       i_en_disp,
   input  logic       i_err_disp,
   input  logic [3:0] i_sec_l,
   input  logic [3:0] i_sec_m,
   input  logic [3:0] i_min_l,
   input  logic [3:0] i_min_m,
   input  logic [3:0] i_hour_l,
   input  logic [3:0] i_hour_m,
   output logic [6:0] o_seg,
   output logic [5:0] o_dig_sel,
   output logic       o_frame_done
);

   localparam int SLOT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
   localparam int CNT_W    = $clog2(SLOT_MAX + 1);
   localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

   state_e                     state_q, state_d;
   logic [2:0]                 idx_q, idx_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [NUM_DIGITS-1:0][3:0] shd_q, shd_d;
   logic                       err_q, err_d;
   logic [6:0]                 seg_q, seg_d;
   logic [5:0]                 sel_q, sel_d;
   logic                       done_q, done_d;
   logic                       adv;
   logic [3:0]                 cur_bcd;
   logic [6:0]                 cur_seg;

   // Losing the enable mid-frame takes priority over finishing the slot.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      done_d  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         IDLE: if (i_en_disp) state_d = LOAD;
         LOAD: begin
            state_d = ON;
            idx_d   = 3'd0;
         end
         ON: begin
            if (!i_en_disp) state_d = IDLE;
            else if (cnt_q == ON_LAST) begin
               if (DEAD_CYC > 0) state_d = DEAD;
               else              adv = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         end
         DEAD: begin
            if (!i_en_disp)              state_d = IDLE;
            else if (cnt_q == DEAD_LAST) adv = 1'b1;
            else                         cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (adv) begin
         if (idx_q < 3'd5) begin
            idx_d   = idx_q + 3'd1;
            state_d = ON;
         end else begin
            done_d  = 1'b1;
            state_d = i_en_disp ? LOAD : IDLE;
         end
      end
   end

   always_comb begin
      cur_bcd = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_d == 3'(i)) cur_bcd = shd_q[i];
      end
   end

   bcd_to_seg u_dec (
      .i_bcd (cur_bcd),
      .o_seg (cur_seg)
   );

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      shd_d = shd_q;
      err_d = err_q;
      seg_d = SEG_OFF;
      sel_d = '0;
      if (state_d == LOAD) begin
         shd_d = {i_hour_m, i_hour_l, i_min_m, i_min_l, i_sec_m, i_sec_l};
         err_d = i_err_disp;
      end
      if (state_d == ON) begin
         sel_d = 6'b1 << idx_d;
         seg_d = err_q ? SEG_DASH : cur_seg;
`ifdef DISP_LZB_EN
         if (!err_q && idx_d == 3'd5 && shd_q[5] == 4'd0) seg_d = SEG_OFF;
`else
`endif
      end
   end

   always_ff @(posedge i_clk_disp or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         shd_q   <= '0;
         err_q   <= 1'b0;
         seg_q   <= SEG_OFF;
         sel_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         shd_q   <= shd_d;
         err_q   <= err_d;
         seg_q   <= seg_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
      end
   end

   assign o_seg        = seg_q;
   assign o_dig_sel    = sel_q;
   assign o_frame_done = done_q;

endmodule

// File: tb/tb_seg_disp_scan.sv
// Directed bench for seg_disp_scan: a default-timing instance and a SCAN_DIV=1/DEAD_CYC=0 instance.
module tb_seg_disp_scan;

   typedef struct {
      logic [5:0] sel;
      logic [6:0] seg;
      logic       done;
   } exp_t;

`ifdef DISP_LZB_EN
   localparam logic [6:0] HM0 = 7'h00;
`else
   localparam logic [6:0] HM0 = 7'h3F;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, en_f, err;
   logic [3:0] sec_l, sec_m, min_l, min_m, hour_l, hour_m;
   logic [6:0] seg, seg_f;
   logic [5:0] sel, sel_f;
   logic       done, done_f;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   seg_disp_scan u_dut (
      .i_clk_disp (clk), .i_rst_n (rst_n), .i_en_disp (en), .i_err_disp (err),
      .i_sec_l (sec_l), .i_sec_m (sec_m), .i_min_l (min_l), .i_min_m (min_m),
      .i_hour_l (hour_l), .i_hour_m (hour_m),
      .o_seg (seg), .o_dig_sel (sel), .o_frame_done (done)
   );

   seg_disp_scan #(.SCAN_DIV(1), .DEAD_CYC(0)) u_fast (
      .i_clk_disp (clk), .i_rst_n (rst_n), .i_en_disp (en_f), .i_err_disp (err),
      .i_sec_l (sec_l), .i_sec_m (sec_m), .i_min_l (min_l), .i_min_m (min_m),
      .i_hour_l (hour_l), .i_hour_m (hour_m),
      .o_seg (seg_f), .o_dig_sel (sel_f), .o_frame_done (done_f)
   );

   task automatic cmp(input string tag, input int cyc, input logic [5:0] s, input logic [6:0] g,
                      input logic d, input exp_t e);
      checks++;
      if (s !== e.sel || g !== e.seg || d !== e.done) begin
         errors++;
         $display("FAIL %s cyc %0d: sel=%h seg=%h done=%b required sel=%h seg=%h done=%b",
                  tag, cyc, s, g, d, e.sel, e.seg, e.done);
      end else
         $display("ok   %s cyc %0d: sel=%h seg=%h done=%b", tag, cyc, s, g, d);
   endtask

   // Table of one frame: LOAD entry, then per digit on_len ON cycles and dead_len DEAD cycles.
   task automatic run_frame(input string tag, input bit fast, input logic [5:0][6:0] segs,
                            input logic done0, input int chg_at, input int stop_at);
      exp_t tbl[$];
      exp_t e;
      int   on_len   = fast ? 1 : 3;
      int   dead_len = fast ? 0 : 1;
      e.sel = 6'h00; e.seg = 7'h00; e.done = done0;
      tbl.push_back(e);
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < on_len; j++) begin
            e.sel = 6'b1 << k; e.seg = segs[k]; e.done = 1'b0;
            tbl.push_back(e);
         end
         for (int j = 0; j < dead_len; j++) begin
            e.sel = 6'h00; e.seg = 7'h00; e.done = 1'b0;
            tbl.push_back(e);
         end
      end
      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         if (fast) cmp(tag, i, sel_f, seg_f, done_f, tbl[i]);
         else      cmp(tag, i, sel, seg, done, tbl[i]);
         if (i == chg_at) min_l = 4'd1;
         if (i == stop_at) return;
      end
   endtask

   task automatic expect_off(input string tag, input int n);
      exp_t z;
      z.sel = 6'h00; z.seg = 7'h00; z.done = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cmp(tag, i, sel, seg, done, z);
      end
   endtask

   initial begin
      exp_t z;
      logic [5:0][6:0] s_base, s_new, s_err, s_bad;
      z.sel = 6'h00; z.seg = 7'h00; z.done = 1'b0;
      s_base = {HM0, 7'h3F, 7'h4F, 7'h3F, 7'h66, 7'h6D};
      s_new  = {HM0, 7'h3F, 7'h4F, 7'h06, 7'h66, 7'h6D};
      s_err  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      s_bad  = {HM0, 7'h3F, 7'h4F, 7'h06, 7'h66, 7'h40};

      rst_n = 1'b0; en = 1'b0; en_f = 1'b0; err = 1'b0;
      hour_m = 4'd0; hour_l = 4'd0; min_m = 4'd3; min_l = 4'd0; sec_m = 4'd4; sec_l = 4'd5;
      repeat (3) @(posedge clk);
      #1;
      cmp("reset", 0, sel, seg, done, z);
      cmp("reset_fast", 0, sel_f, seg_f, done_f, z);
      rst_n = 1'b1;
      en    = 1'b1;

      run_frame("frame_a", 1'b0, s_base, 1'b0, -1, -1);
      run_frame("frame_b", 1'b0, s_base, 1'b1, 2, -1);
      run_frame("frame_c", 1'b0, s_new, 1'b1, -1, -1);
      err = 1'b1;
      run_frame("frame_err", 1'b0, s_err, 1'b1, -1, -1);
      err = 1'b0; sec_l = 4'd12;
      run_frame("frame_bad", 1'b0, s_bad, 1'b1, -1, -1);
      sec_l = 4'd5;
      run_frame("frame_abort", 1'b0, s_new, 1'b1, -1, 13);
      en = 1'b0;
      expect_off("aborted", 6);
      en = 1'b1;
      run_frame("frame_restart", 1'b0, s_new, 1'b0, -1, -1);
      en = 1'b0;
      expect_off("disabled", 3);

      en_f = 1'b1;
      run_frame("fast_a", 1'b1, s_new, 1'b0, -1, -1);
      run_frame("fast_b", 1'b1, s_new, 1'b1, -1, -1);
      en_f = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      en = 1'b1;
      run_frame("pre_reset", 1'b0, s_new, 1'b0, -1, 2);
      #2 rst_n = 1'b0;
      #1 cmp("async_reset", 0, sel, seg, done, z);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_frame("post_reset", 1'b0, s_new, 1'b0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
